// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared state encodings and defaults for the UART receive framing controller.
package uart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
  localparam int         TIMEOUT_CLKS_DEF = 2000;

endpackage

// File: rtl/uart_rx_frame_wrptr.sv
// Circular buffer write pointer with a frame-base register; rewind beats increment.
module uart_rx_frame_wrptr #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              latch_base,
  input  logic              rewind,
  output logic [ADDR_W-1:0] o_ptr,
  output logic [ADDR_W-1:0] o_base
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;

  always_comb begin
    base_d = latch_base ? ptr_q : base_q;
    if (rewind) begin
      ptr_d = base_q;
    end else if (inc) begin
      ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      base_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      base_q <= base_d;
    end
  end

  assign o_ptr  = ptr_q;
  assign o_base = base_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framing controller: sync/len/payload/XOR-checksum parser into a circular buffer.
// Define UART_RX_FRAME_STATS_EN to add saturating frame / checksum-error / timeout counters.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         ADDR_W       = 13,
  parameter int         DEPTH        = 8192,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic              i_Clock,
  input  logic              RESET,
  input  logic              i_enable,
  input  logic              i_save_byte,
  input  logic [7:0]        i_rx_byte,
  output logic              o_rx_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_frame_ready,
  output logic [ADDR_W-1:0] o_frame_base,
  output logic [7:0]        o_frame_len,
  input  logic              i_frame_ack,
  output logic              o_csum_err,
  output logic              o_timeout_err,
  output logic              o_overrun
`ifdef UART_RX_FRAME_STATS_EN
  ,
  output logic [15:0]       o_frame_cnt,
  output logic [7:0]        o_csum_err_cnt,
  output logic [7:0]        o_timeout_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  state_e            state_q, state_d;
  logic              save_prev_q, save_prev_d;
  logic              rx_en_q, rx_en_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        remain_q, remain_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              frame_ready_q, frame_ready_d;
  logic              csum_err_q, csum_err_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              ptr_inc, ptr_latch, ptr_rewind;
  logic [ADDR_W-1:0] ptr, base;
  logic              byte_evt, timed;
`ifdef UART_RX_FRAME_STATS_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]        csum_err_cnt_q, csum_err_cnt_d;
  logic [7:0]        timeout_cnt_q, timeout_cnt_d;
`endif

  assign byte_evt = i_save_byte & ~save_prev_q;
  assign timed    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  uart_rx_frame_wrptr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wrptr (
    .clk        (i_Clock),
    .rst_n      (RESET),
    .inc        (ptr_inc),
    .latch_base (ptr_latch),
    .rewind     (ptr_rewind),
    .o_ptr      (ptr),
    .o_base     (base)
  );

  always_comb begin
    state_d       = state_q;
    save_prev_d   = i_save_byte;
    rx_en_d       = i_enable;
    len_d         = len_q;
    remain_d      = remain_q;
    csum_d        = csum_q;
    timer_d       = '0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    frame_ready_d = frame_ready_q;
    csum_err_d    = 1'b0;
    timeout_d     = 1'b0;
    overrun_d     = overrun_q;
    ptr_inc       = 1'b0;
    ptr_latch     = 1'b0;
    ptr_rewind    = 1'b0;

    if (!i_enable) begin
      // Only PAYLOAD/CSUM have bytes of the current frame in the buffer to discard.
      state_d       = ST_HUNT;
      frame_ready_d = 1'b0;
      overrun_d     = 1'b0;
      ptr_rewind    = (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    end else begin
      if (timed && !byte_evt) timer_d = timer_q + TW'(1);
      case (state_q)
        ST_HUNT: begin
          if (byte_evt && (i_rx_byte == SYNC_BYTE)) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (byte_evt) begin
            len_d     = i_rx_byte;
            remain_d  = i_rx_byte;
            csum_d    = 8'h00;
            ptr_latch = 1'b1;
            state_d   = (i_rx_byte == 8'h00) ? ST_CSUM : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (byte_evt) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr;
            mem_wdata_d = i_rx_byte;
            ptr_inc     = 1'b1;
            csum_d      = csum_q ^ i_rx_byte;
            remain_d    = remain_q - 8'd1;
            if (remain_q == 8'd1) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (byte_evt) begin
            if (i_rx_byte == csum_q) begin
              state_d       = ST_DONE;
              frame_ready_d = 1'b1;
            end else begin
              csum_err_d = 1'b1;
              ptr_rewind = 1'b1;
              state_d    = ST_HUNT;
            end
          end
        end
        ST_DONE: begin
          if (byte_evt) overrun_d = 1'b1;
          if (i_frame_ack) begin
            frame_ready_d = 1'b0;
            state_d       = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      // In LEN the base has not been latched for this frame, so it must not be rewound to.
      if (timed && !byte_evt && (timer_q == TW'(TIMEOUT_CLKS - 1))) begin
        timeout_d  = 1'b1;
        timer_d    = '0;
        state_d    = ST_HUNT;
        ptr_rewind = (state_q != ST_LEN);
      end
    end

`ifdef UART_RX_FRAME_STATS_EN
    frame_cnt_d    = frame_cnt_q;
    csum_err_cnt_d = csum_err_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    if ((state_q == ST_CSUM) && (state_d == ST_DONE) && (frame_cnt_q != 16'hFFFF))
      frame_cnt_d = frame_cnt_q + 16'd1;
    if (csum_err_d && (csum_err_cnt_q != 8'hFF)) csum_err_cnt_d = csum_err_cnt_q + 8'd1;
    if (timeout_d && (timeout_cnt_q != 8'hFF)) timeout_cnt_d = timeout_cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge i_Clock) begin
    if (!RESET) begin
      state_q       <= ST_HUNT;
      save_prev_q   <= 1'b0;
      rx_en_q       <= 1'b0;
      len_q         <= '0;
      remain_q      <= '0;
      csum_q        <= '0;
      timer_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      frame_ready_q <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_FRAME_STATS_EN
      frame_cnt_q    <= '0;
      csum_err_cnt_q <= '0;
      timeout_cnt_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      save_prev_q   <= save_prev_d;
      rx_en_q       <= rx_en_d;
      len_q         <= len_d;
      remain_q      <= remain_d;
      csum_q        <= csum_d;
      timer_q       <= timer_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      frame_ready_q <= frame_ready_d;
      csum_err_q    <= csum_err_d;
      timeout_q     <= timeout_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_FRAME_STATS_EN
      frame_cnt_q    <= frame_cnt_d;
      csum_err_cnt_q <= csum_err_cnt_d;
      timeout_cnt_q  <= timeout_cnt_d;
`endif
    end
  end

  assign o_rx_en       = rx_en_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_frame_ready = frame_ready_q;
  assign o_frame_base  = base;
  assign o_frame_len   = len_q;
  assign o_csum_err    = csum_err_q;
  assign o_timeout_err = timeout_q;
  assign o_overrun     = overrun_q;
`ifdef UART_RX_FRAME_STATS_EN
  assign o_frame_cnt    = frame_cnt_q;
  assign o_csum_err_cnt = csum_err_cnt_q;
  assign o_timeout_cnt  = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: frame-level model predicts writes, descriptors and errors.
module tb_uart_rx_frame_ctrl;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;
  localparam int TO     = 2000;

  logic              i_Clock = 1'b0;
  logic              RESET = 1'b0;
  logic              i_enable = 1'b0;
  logic              i_save_byte = 1'b0;
  logic [7:0]        i_rx_byte = 8'h00;
  logic              i_frame_ack = 1'b0;
  logic              o_rx_en, o_mem_we, o_frame_ready, o_csum_err, o_timeout_err, o_overrun;
  logic [ADDR_W-1:0] o_mem_addr, o_frame_base;
  logic [7:0]        o_mem_wdata, o_frame_len;
`ifdef UART_RX_FRAME_STATS_EN
  logic [15:0]       o_frame_cnt;
  logic [7:0]        o_csum_err_cnt, o_timeout_cnt;
`endif

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_evt = 0;
  bit         check_en = 1'b0;
  int         exp_wq[$];
  int         wlog[$];
  int         exp_csum_err = 0;
  int         exp_timeout = 0;
  int         exp_base = 0;
  int         exp_len = 0;
  bit         exp_ready = 1'b0;
  int         m_ptr = 0;
  logic [7:0] pl[$];

  uart_rx_frame_ctrl dut (
    .i_Clock       (i_Clock),
    .RESET         (RESET),
    .i_enable      (i_enable),
    .i_save_byte   (i_save_byte),
    .i_rx_byte     (i_rx_byte),
    .o_rx_en       (o_rx_en),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_frame_ready (o_frame_ready),
    .o_frame_base  (o_frame_base),
    .o_frame_len   (o_frame_len),
    .i_frame_ack   (i_frame_ack),
    .o_csum_err    (o_csum_err),
    .o_timeout_err (o_timeout_err),
    .o_overrun     (o_overrun)
`ifdef UART_RX_FRAME_STATS_EN
    ,
    .o_frame_cnt    (o_frame_cnt),
    .o_csum_err_cnt (o_csum_err_cnt),
    .o_timeout_cnt  (o_timeout_cnt)
`endif
  );

  always #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One receiver strobe of w cycles followed by g idle cycles; the edge after raising it is the event.
  task automatic applyStimulus(input logic [7:0] b, input int w, input int g);
    @(posedge i_Clock);
    #1;
    i_rx_byte   = b;
    i_save_byte = 1'b1;
    last_evt    = cyc + 1;
    repeat (w) @(posedge i_Clock);
    #1;
    i_save_byte = 1'b0;
    repeat (g) @(posedge i_Clock);
  endtask

  task automatic ack_frame();
    @(posedge i_Clock);
    #1 i_frame_ack = 1'b1;
    @(posedge i_Clock);
    #1 i_frame_ack = 1'b0;
    exp_ready = 1'b0;
    @(negedge i_Clock);
    checkOutput("ready_cleared_after_ack", 32'(o_frame_ready), 0);
  endtask

  // Frame-level model: payload lands at consecutive addresses mod DEPTH; a good XOR
  // publishes a descriptor and advances the pointer, a bad one reports and leaves it alone.
  task automatic send_frame(input logic [7:0] csum, input int w, input int g, input bit do_ack);
    logic [7:0] x;
    bit         good;
    x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    good = (x == csum);
    foreach (pl[i]) exp_wq.push_back((((m_ptr + i) % DEPTH) << 8) | int'(pl[i]));
    applyStimulus(8'hA5, w, g);
    applyStimulus(8'(pl.size()), w, g);
    foreach (pl[i]) applyStimulus(pl[i], w, g);
    if (good) begin
      exp_base  = m_ptr;
      exp_len   = pl.size();
      exp_ready = 1'b1;
    end else begin
      exp_csum_err++;
    end
    applyStimulus(csum, w, g);
    @(negedge i_Clock);
    checkOutput("writes_drained", 32'(exp_wq.size()), 0);
    if (good) begin
      checkOutput("frame_ready", 32'(o_frame_ready), 1);
      checkOutput("frame_base", 32'(o_frame_base), 32'(exp_base));
      checkOutput("frame_len", 32'(o_frame_len), 32'(exp_len));
      m_ptr = (m_ptr + pl.size()) % DEPTH;
      if (do_ack) ack_frame();
    end else begin
      checkOutput("csum_err_seen", 32'(exp_csum_err), 0);
    end
  endtask

  always @(negedge i_Clock) begin
    if (check_en) begin
      if (o_mem_we) begin
        wlog.push_back((int'(o_mem_addr) << 8) | int'(o_mem_wdata));
        checkOutput("write_expected", 32'(exp_wq.size() > 0), 1);
        if (exp_wq.size() > 0)
          checkOutput("write_addr_data", 32'({o_mem_addr, o_mem_wdata}), 32'(exp_wq.pop_front()));
      end
      if (o_csum_err) begin
        checkOutput("csum_err_expected", 32'(exp_csum_err > 0), 1);
        if (exp_csum_err > 0) exp_csum_err--;
        checkOutput("csum_err_vs_ready", 32'(o_frame_ready), 0);
      end
      if (o_timeout_err) begin
        checkOutput("timeout_expected", 32'(exp_timeout > 0), 1);
        if (exp_timeout > 0) exp_timeout--;
        checkOutput("timeout_gap", 32'((cyc - last_evt >= TO) && (cyc - last_evt <= TO + 2)), 1);
        checkOutput("timeout_vs_ready", 32'(o_frame_ready), 0);
      end
      if (o_frame_ready) begin
        checkOutput("ready_expected", 32'(exp_ready), 1);
        checkOutput("ready_base", 32'(o_frame_base), 32'(exp_base));
        checkOutput("ready_len", 32'(o_frame_len), 32'(exp_len));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] x;
    logic [7:0] b;
    int         n;

    i_enable = 1'b1;
    repeat (3) @(posedge i_Clock);
    @(negedge i_Clock);
    checkOutput("rst_rx_en", 32'(o_rx_en), 0);
    checkOutput("rst_mem_we", 32'(o_mem_we), 0);
    checkOutput("rst_mem_addr", 32'(o_mem_addr), 0);
    checkOutput("rst_mem_wdata", 32'(o_mem_wdata), 0);
    checkOutput("rst_frame_ready", 32'(o_frame_ready), 0);
    checkOutput("rst_frame_base", 32'(o_frame_base), 0);
    checkOutput("rst_frame_len", 32'(o_frame_len), 0);
    checkOutput("rst_csum_err", 32'(o_csum_err), 0);
    checkOutput("rst_timeout_err", 32'(o_timeout_err), 0);
    checkOutput("rst_overrun", 32'(o_overrun), 0);
    @(posedge i_Clock);
    #1 RESET = 1'b1;
    check_en = 1'b1;
    repeat (2) @(negedge i_Clock);
    checkOutput("rx_en_follows_enable", 32'(o_rx_en), 1);

    // Non-sync bytes while hunting are never written.
    applyStimulus(8'h33, 7, 3);
    applyStimulus(8'h10, 7, 3);

    pl = '{8'h10, 8'h20, 8'h03};
    wlog.delete();
    send_frame(8'h33, 7, 3, 1'b0);
    checkOutput("f1_base_literal", 32'(o_frame_base), 0);
    checkOutput("f1_len_literal", 32'(o_frame_len), 3);
    checkOutput("f1_write_count", 32'(wlog.size()), 3);
    if (wlog.size() == 3) begin
      checkOutput("f1_write0", 32'(wlog[0]), 32'h0010);
      checkOutput("f1_write1", 32'(wlog[1]), 32'h0120);
      checkOutput("f1_write2", 32'(wlog[2]), 32'h0203);
    end
    ack_frame();

    pl = '{8'h11, 8'h22};
    send_frame(8'h00, 7, 3, 1'b1);
    pl = '{8'h55};
    send_frame(8'h55, 7, 3, 1'b0);
    checkOutput("after_bad_base_literal", 32'(o_frame_base), 3);
    ack_frame();

    pl.delete();
    send_frame(8'h00, 7, 3, 1'b0);
    checkOutput("len0_len_literal", 32'(o_frame_len), 0);
    checkOutput("len0_base_literal", 32'(o_frame_base), 4);
    ack_frame();

    // Partial frame A5 04 01 then silence: one write, one timeout, pointer restored.
    exp_wq.push_back((m_ptr << 8) | 1);
    applyStimulus(8'hA5, 7, 3);
    applyStimulus(8'h04, 7, 3);
    exp_timeout = 1;
    applyStimulus(8'h01, 7, 3);
    for (int k = 0; (k < TO + 100) && (exp_timeout != 0); k++) @(negedge i_Clock);
    checkOutput("timeout_seen", 32'(exp_timeout), 0);
    checkOutput("timeout_writes_drained", 32'(exp_wq.size()), 0);
    repeat (20) @(negedge i_Clock);

    // Fill traffic to move the pointer from 4 up to 8190.
    for (int f = 0; f < 33; f++) begin
      pl.delete();
      n = (f < 32) ? 255 : 26;
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        b = 8'((f * 37) + (k * 11) + 1);
        pl.push_back(b);
        x ^= b;
      end
      send_frame(x, 2, 1, 1'b1);
      if (f == 0) checkOutput("fill_base_after_timeout", 32'(o_frame_base), 4);
    end

    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wlog.delete();
    send_frame(8'h22, 7, 3, 1'b0);
    checkOutput("wrap_base_literal", 32'(o_frame_base), 8190);
    checkOutput("wrap_write_count", 32'(wlog.size()), 4);
    if (wlog.size() == 4) begin
      checkOutput("wrap_addr0", 32'(wlog[0] >> 8), 8190);
      checkOutput("wrap_addr1", 32'(wlog[1] >> 8), 8191);
      checkOutput("wrap_addr2", 32'(wlog[2] >> 8), 0);
      checkOutput("wrap_addr3", 32'(wlog[3] >> 8), 1);
    end

    // A byte arriving while a descriptor is held is dropped and flagged.
    applyStimulus(8'h5A, 7, 3);
    @(negedge i_Clock);
    checkOutput("overrun_set", 32'(o_overrun), 1);
    checkOutput("ready_held_in_done", 32'(o_frame_ready), 1);

    @(posedge i_Clock);
    #1 i_enable = 1'b0;
    @(posedge i_Clock);
    #1 exp_ready = 1'b0;
    @(negedge i_Clock);
    checkOutput("disable_rx_en", 32'(o_rx_en), 0);
    checkOutput("disable_overrun", 32'(o_overrun), 0);
    checkOutput("disable_ready", 32'(o_frame_ready), 0);
    checkOutput("final_writes_drained", 32'(exp_wq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
